// File: rtl/fifo_rd_showahead_pkg.sv
// Shared helpers for the show-ahead read adapter:
// ring sizing and the legal read-latency range.
package fifo_rd_showahead_pkg;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

  // Two spare slots beyond the latency keep full rate.
  function automatic int buf_depth(input int read_latency);
    return read_latency + 2;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_ring.sv
// Small register ring with push/pop, explicit pointer wrap
// for non-power-of-two depths, and an entry count.
module fifo_rd_ring
  import fifo_rd_showahead_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 3,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;

  assign w_wr_nxt = (r_wr_ptr == LAST) ? '0
                  : r_wr_ptr + PW'(1);
  assign w_rd_nxt = (r_rd_ptr == LAST) ? '0
                  : r_rd_ptr + PW'(1);

  // Storage is data-only; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= w_wr_nxt;
      end
      if (i_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_showahead.sv
// Show-ahead valid/ready adapter on a normal-mode FIFO
// read port; credits cover ring entries plus reads in flight.
module fifo_rd_showahead
  import fifo_rd_showahead_pkg::*;
#(
  parameter  int WIDTH        = 20,
  parameter  int READ_LATENCY = 1,
  localparam int BUF_DEPTH    = buf_depth(READ_LATENCY),
  localparam int CW           = cnt_width(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             aclr,
  output logic             fifo_rdreq,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  if (READ_LATENCY < MIN_READ_LATENCY ||
      READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("fifo_rd_showahead: READ_LATENCY %0d illegal",
           READ_LATENCY);
  end

  logic [READ_LATENCY-1:0] r_inflight;
  logic [CW-1:0]           w_inflight_cnt;
  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_total;
  logic                    w_rdreq;
  logic                    w_capture;
  logic                    w_pop;

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + CW'(r_inflight[i]);
    end
  end

  assign w_total = w_count + w_inflight_cnt;

  // Depends on fifo_empty and own state only, never on ready.
  assign w_rdreq = ~aclr & ~fifo_empty &
                   (w_total < CW'(BUF_DEPTH));

  assign w_capture = r_inflight[READ_LATENCY-1];
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_inflight <= '0;
    end else begin
      r_inflight[0] <= w_rdreq;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
    end
  end

  fifo_rd_ring #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_ring (
    .clk         (clk),
    .aclr        (aclr),
    .i_push      (w_capture),
    .i_push_data (fifo_q),
    .i_pop       (w_pop),
    .o_data      (out_data),
    .o_count     (w_count)
  );

  assign fifo_rdreq = w_rdreq;
  assign out_valid  = (w_count != '0);
  assign occupancy  = w_total;

endmodule

// File: tb/tb_fifo_rd_showahead.sv
// Directed and soak bench: four adapters (latency 1..4)
// each on its own behavioural FIFO model.
module tb_fifo_rd_showahead;
  import fifo_rd_showahead_pkg::*;

  logic       clk;
  logic       aclr;
  logic [3:0] rdreq;
  logic [3:0] empty;
  logic [3:0] ov;
  logic [3:0] rdy;
  logic [19:0] q     [4];
  logic [19:0] odata [4];
  logic [2:0]  occ   [4];

  logic [19:0] mem   [4][256];
  logic [15:0] wp    [4];
  logic [15:0] rp    [4];
  logic [19:0] wval  [4];
  logic [19:0] qpipe [4][4];
  int          uf    [4];

  logic [3:0]  wr_mask;
  int          wr_n;
  logic        wr_load;
  logic [19:0] wr_base;
  logic        force_ne;

  int errors;
  int checks;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = cnt_width(buf_depth(g + 1));
    logic [CW-1:0] w_occ;
    fifo_rd_showahead #(
      .WIDTH        (20),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk        (clk),
      .aclr       (aclr),
      .fifo_rdreq (rdreq[g]),
      .fifo_empty (empty[g]),
      .fifo_q     (q[g]),
      .out_valid  (ov[g]),
      .out_data   (odata[g]),
      .out_ready  (rdy[g]),
      .occupancy  (w_occ)
    );
    assign occ[g] = 3'(w_occ);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    empty = '0;
    for (int k = 0; k < 4; k++) begin
      q[k]     = qpipe[k][k];
      empty[k] = force_ne ? 1'b0 : (wp[k] == rp[k]);
    end
  end

  // Normal-mode FIFO: q valid READ_LATENCY-1 edges after rdreq edge.
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < 4; k++) begin
        wp[k]   <= '0;
        rp[k]   <= '0;
        wval[k] <= 20'd1;
        uf[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rdreq[k]) begin
          if (wp[k] == rp[k]) uf[k] <= uf[k] + 1;
          qpipe[k][0] <= mem[k][rp[k][7:0]];
          rp[k] <= rp[k] + 16'd1;
        end
        for (int j = 1; j < 4; j++) begin
          qpipe[k][j] <= qpipe[k][j-1];
        end
        if (wr_mask[k]) begin
          for (int n = 0; n < wr_n; n++) begin
            mem[k][8'(wp[k] + 16'(n))] <=
              (wr_load ? wr_base : wval[k]) + 20'(n);
          end
          wp[k]   <= wp[k] + 16'(wr_n);
          wval[k] <= (wr_load ? wr_base : wval[k]) + 20'(wr_n);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    aclr = 1'b1;
    wr_mask = '0;
    rdy = '0;
    force_ne = 1'b0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    aclr = 1'b1;
    force_ne = 1'b1;
    wr_mask = '0;
    rdy = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rdreq !== 4'h0 || ov !== 4'h0 || occ[0] !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d rdreq=%b valid=%b occ=%0d exp 0",
                 c, rdreq, ov, occ[0]);
      end
    end
    aclr = 1'b0;
    #1;
    checks++;
    if (rdreq !== 4'hF) begin
      errors++;
      $display("FAIL reset_release rdreq=%b exp 1111", rdreq);
    end
    force_ne = 1'b0;
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    @(negedge clk);
    wr_mask = '1;
    wr_n = 8;
    wr_load = 1'b0;
    rdy = '1;
    @(negedge clk);
    wr_mask = '0;
    checks++;
    if (rdreq[1] !== 1'b1 || ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat_start rdreq=%b valid=%b exp 1/0",
               rdreq[1], ov[1]);
    end
    lat = 0;
    while (ov[1] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL lat_first got %0d cycles exp 3", lat);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ov[1] !== 1'b1 || odata[1] !== 20'(i + 1)) begin
        errors++;
        $display("FAIL lat_data i=%0d valid=%b got %h exp %h",
                 i, ov[1], odata[1], 20'(i + 1));
      end
      @(negedge clk);
    end
    checks++;
    if (ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat_end valid=%b exp 0", ov[1]);
    end
  endtask

  task automatic test_stall();
    logic [19:0] exp;
    int guard;
    do_reset();
    @(negedge clk);
    wr_mask = '1;
    wr_n = 20;
    wr_load = 1'b0;
    rdy = '1;
    @(negedge clk);
    wr_mask = '0;
    exp = 20'd1;
    repeat (5) begin
      if (ov[0]) begin
        checks++;
        if (odata[0] !== exp) begin
          errors++;
          $display("FAIL stall_pre got %h exp %h", odata[0], exp);
        end
        exp++;
      end
      @(negedge clk);
    end
    rdy[0] = 1'b0;
    for (int s = 0; s < 10; s++) begin
      checks++;
      if (ov[0] !== 1'b1 || odata[0] !== exp) begin
        errors++;
        $display("FAIL stall_hold s=%0d valid=%b got %h exp %h",
                 s, ov[0], odata[0], exp);
      end
      if (s >= 1) begin
        checks++;
        if (occ[0] !== 3'd3 || rdreq[0] !== 1'b0) begin
          errors++;
          $display("FAIL stall_sat s=%0d occ=%0d rdreq=%b exp 3/0",
                   s, occ[0], rdreq[0]);
        end
      end
      @(negedge clk);
    end
    rdy[0] = 1'b1;
    guard = 0;
    while (exp <= 20'd20 && guard < 40) begin
      if (ov[0]) begin
        checks++;
        if (odata[0] !== exp) begin
          errors++;
          $display("FAIL stall_post got %h exp %h", odata[0], exp);
        end
        exp++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp !== 20'd21) begin
      errors++;
      $display("FAIL stall_drain next=%0d exp 21", exp);
    end
  endtask

  task automatic test_empty();
    int beats [4];
    do_reset();
    @(negedge clk);
    wr_mask = '1;
    wr_n = 1;
    wr_load = 1'b1;
    wr_base = 20'h5A;
    rdy = '1;
    @(negedge clk);
    wr_mask = '0;
    wr_load = 1'b0;
    for (int k = 0; k < 4; k++) beats[k] = 0;
    repeat (12) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k]) begin
          beats[k]++;
          checks++;
          if (odata[k] !== 20'h5A) begin
            errors++;
            $display("FAIL empty_data k=%0d got %h exp 5a",
                     k, odata[k]);
          end
        end
        checks++;
        if (empty[k] && rdreq[k]) begin
          errors++;
          $display("FAIL empty_rdreq k=%0d rdreq=1 exp 0", k);
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (beats[k] != 1 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL empty_beats k=%0d got %0d valid=%b exp 1/0",
                 k, beats[k], ov[k]);
      end
    end
  endtask

  task automatic test_midreset();
    logic [19:0] exp;
    int guard;
    do_reset();
    @(negedge clk);
    wr_mask = '1;
    wr_n = 10;
    wr_load = 1'b0;
    rdy = '1;
    @(negedge clk);
    wr_mask = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (occ[3] !== 3'd2 || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre occ=%0d valid0=%b exp 2/1",
               occ[3], ov[0]);
    end
    aclr = 1'b1;
    #1;
    checks++;
    if (ov !== 4'h0) begin
      errors++;
      $display("FAIL mid_valid got %b exp 0000", ov);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (occ[k] !== 3'd0) begin
        errors++;
        $display("FAIL mid_occ k=%0d got %0d exp 0", k, occ[k]);
      end
    end
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    wr_mask = '1;
    wr_n = 3;
    wr_load = 1'b1;
    wr_base = 20'h100;
    @(negedge clk);
    wr_mask = '0;
    wr_load = 1'b0;
    exp = 20'h100;
    guard = 0;
    while (exp < 20'h103 && guard < 30) begin
      if (ov[3]) begin
        checks++;
        if (odata[3] !== exp) begin
          errors++;
          $display("FAIL mid_restart got %h exp %h", odata[3], exp);
        end
        exp++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp !== 20'h103) begin
      errors++;
      $display("FAIL mid_count next=%h exp 103", exp);
    end
  endtask

  task automatic test_soak();
    logic [19:0] exp [4];
    do_reset();
    for (int k = 0; k < 4; k++) exp[k] = 20'd1;
    wr_n = 1;
    wr_load = 1'b0;
    for (int cyc = 0; cyc < 10060; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (cyc < 10000) begin
          rdy[k] = ($urandom_range(0, 3) != 0);
          wr_mask[k] = ($urandom_range(0, 1) == 1) &&
                       (16'(wp[k] - rp[k]) < 16'd200);
        end else begin
          rdy[k] = 1'b1;
          wr_mask[k] = 1'b0;
        end
        if (ov[k] && rdy[k]) begin
          checks++;
          if (odata[k] !== exp[k]) begin
            errors++;
            $display("FAIL soak_data k=%0d got %h exp %h",
                     k, odata[k], exp[k]);
          end
          exp[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (uf[k] != 0 || exp[k] !== wval[k] || exp[k] < 20'd1000) begin
        errors++;
        $display("FAIL soak_end k=%0d uf=%0d read=%0d wrote=%0d",
                 k, uf[k], exp[k], wval[k]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    aclr = 1'b0;
    wr_mask = '0;
    wr_n = 0;
    wr_load = 1'b0;
    wr_base = '0;
    force_ne = 1'b0;
    rdy = '0;
    #1 aclr = 1'b1;
    test_reset();
    test_latency();
    test_stall();
    test_empty();
    test_midreset();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
